// File: rtl/spi_burst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_burst_sequencer                                              |
// | Purpose : TX/RX byte FIFOs plus a burst FSM driving a byte-level SPI master |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module spi_burst_sequencer #(
  parameter int         FIFO_AW   = 3,
  parameter int         LEN_W     = 8,
  parameter int         CS_DLY    = 2,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_wr,
  input  logic [7:0]       tx_data,
  output logic             tx_full,
  input  logic             rx_rd,
  output logic [7:0]       rx_data,
  output logic             rx_empty,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             rx_overflow,
  output logic [7:0]       spi_data,
  output logic             spi_start_n,
  input  logic [7:0]       spi_rx,
  input  logic             spi_done,
  input  logic             spi_idle,
  output logic             cs_n
);

  localparam int c_DEPTH = 1 << FIFO_AW;
  localparam int c_DLY_W = (CS_DLY > 1) ? $clog2(CS_DLY) : 1;
  localparam logic [c_DLY_W-1:0] c_DLY_LAST = c_DLY_W'(CS_DLY - 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_SETUP = 3'd1;
  localparam logic [2:0] c_S_LOAD  = 3'd2;
  localparam logic [2:0] c_S_WAIT  = 3'd3;
  localparam logic [2:0] c_S_GAP   = 3'd4;
  localparam logic [2:0] c_S_HOLD  = 3'd5;

  logic [2:0]         r_state;
  logic [LEN_W-1:0]   r_cnt;
  logic [c_DLY_W-1:0] r_dly;
  logic               r_busy, r_done, r_ovf, r_start_n, r_cs_n;
  logic [7:0]         r_spi_data;

  logic [7:0]         r_tx_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_tx_wp, r_tx_rp;
  logic [FIFO_AW:0]   r_tx_cnt;
  logic [7:0]         r_rx_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_rx_wp, r_rx_rp;
  logic [FIFO_AW:0]   r_rx_cnt;

  logic w_tx_empty, w_tx_pop, w_tx_push;
  logic w_rx_full, w_rx_in, w_rx_pop, w_rx_push, w_rx_drop;

  assign tx_full    = (r_tx_cnt == (FIFO_AW+1)'(c_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_pop   = (r_state == c_S_LOAD) && spi_idle && !w_tx_empty;
  // A full FIFO still accepts a push when the same cycle frees a slot
  assign w_tx_push  = tx_wr && (!tx_full || w_tx_pop);

  assign rx_empty   = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == (FIFO_AW+1)'(c_DEPTH));
  assign w_rx_in    = (r_state == c_S_WAIT) && spi_done;
  assign w_rx_pop   = rx_rd && !rx_empty;
  assign w_rx_push  = w_rx_in && (!w_rx_full || w_rx_pop);
  assign w_rx_drop  = w_rx_in && w_rx_full && !w_rx_pop;
  assign rx_data    = rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= spi_rx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + FIFO_AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + FIFO_AW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + (FIFO_AW+1)'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - (FIFO_AW+1)'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + FIFO_AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + FIFO_AW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + (FIFO_AW+1)'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_S_IDLE;
      r_cnt      <= '0;
      r_dly      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_spi_data <= 8'h00;
      r_start_n  <= 1'b1;
      r_cs_n     <= 1'b1;
    end else begin
      r_done    <= 1'b0;
      r_start_n <= 1'b1;
      if (w_rx_drop) r_ovf <= 1'b1;
      case (r_state)
        c_S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_cnt   <= len;
              r_ovf   <= 1'b0;
              r_busy  <= 1'b1;
              r_cs_n  <= 1'b0;
              r_dly   <= '0;
              r_state <= c_S_SETUP;
            end
          end
        end
        c_S_SETUP: begin
          if (r_dly == c_DLY_LAST) begin
            r_dly   <= '0;
            r_state <= c_S_LOAD;
          end else begin
            r_dly <= r_dly + c_DLY_W'(1);
          end
        end
        c_S_LOAD: begin
          if (spi_idle) begin
            r_start_n  <= 1'b0;
            r_spi_data <= w_tx_empty ? FILL_BYTE : r_tx_mem[r_tx_rp];
            r_state    <= c_S_WAIT;
          end
        end
        c_S_WAIT: begin
          if (spi_done) begin
            if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
            r_state <= (r_cnt <= LEN_W'(1)) ? c_S_HOLD : c_S_GAP;
          end
        end
        c_S_GAP: begin
          if (spi_idle) r_state <= c_S_LOAD;
        end
        c_S_HOLD: begin
          if (r_dly == c_DLY_LAST) begin
            r_dly   <= '0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_S_IDLE;
          end else begin
            r_dly <= r_dly + c_DLY_W'(1);
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rx_overflow = r_ovf;
  assign spi_data    = r_spi_data;
  assign spi_start_n = r_start_n;
  assign cs_n        = r_cs_n;

endmodule
`default_nettype wire
